// File: rtl/ex01f_sweep_ctrl_pkg.sv
// Shared types and constants for the truth-table sweep controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ex01f_sweep_ctrl_pkg;

  localparam int TT_W  = 16;
  localparam int IDX_W = 4;
  localparam int CNT_W = 5;

  // Expected response of the function unit; bit k is s for vector k = {a,b,c,d}.
  localparam logic [TT_W-1:0] GOLDEN_DEF = 16'h20F0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } sweep_state_t;

endpackage

// File: rtl/ex01f_sweep_ctrl_settle_timer.sv
// Settle timer: loadable down-counter, expire pulses on the last counted cycle.
// Latency: expire is combinational, high in the CYCLES-th run cycle after load.
// Backpressure: none; clear (abort) overrides load and run.
//
// Ports: clk, rst_n (sync, active-low), clear, load, run in; expire out.
module sweep_settle_timer #(
  parameter int unsigned CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic load,
  input  logic run,
  output logic expire
);

  logic [3:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CYCLES[3:0];
    end else if (run && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Counter starts at CYCLES, so the cycle that sees 1 is the CYCLES-th one.
  assign expire = run && (cnt == 4'd1);

endmodule

// File: rtl/ex01f_sweep_ctrl.sv
// Exhaustive sweep of a 4-input function unit, capturing its 16-entry truth table.
// Latency: done pulses 16*(SETTLE_CYCLES+1)+1 cycles after an accepted start.
// Backpressure: start ignored unless IDLE; abort returns to IDLE with results invalid.
//
// Ports: clk, rst_n (sync, active-low), start, abort, s_in in;
//        a,b,c,d (vector), busy, done, valid, tt, ones_cnt, match, err_idx out.
module ex01f_sweep_ctrl
  import ex01f_sweep_ctrl_pkg::*;
#(
  parameter int unsigned     SETTLE_CYCLES = 1,
  parameter logic [TT_W-1:0] GOLDEN        = GOLDEN_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             s_in,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  output logic             busy,
  output logic             done,
  output logic             valid,
  output logic [TT_W-1:0]  tt,
  output logic [CNT_W-1:0] ones_cnt,
  output logic             match,
  output logic [IDX_W-1:0] err_idx
);

  sweep_state_t     state_q, state_d;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] vec;
  logic             mis_seen;
  logic             load_timer;
  logic             expire;
  logic             accept;
  logic             do_sample;
  logic             finish;

  sweep_settle_timer #(.CYCLES(SETTLE_CYCLES)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (abort),
    .load   (load_timer),
    .run    (state_q == SETTLE),
    .expire (expire)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    load_timer = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d    = SETTLE;
          load_timer = 1'b1;
        end
      end
      SETTLE: begin
        if (abort)       state_d = IDLE;
        else if (expire) state_d = SAMPLE;
      end
      SAMPLE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (idx == {IDX_W{1'b1}}) begin
          state_d = DONE;
        end else begin
          state_d    = SETTLE;
          load_timer = 1'b1;
        end
      end
      default: state_d = IDLE;  // DONE lasts exactly one cycle
    endcase
  end

  assign accept    = (state_q == IDLE)   && start && !abort;
  assign do_sample = (state_q == SAMPLE) && !abort;
  assign finish    = (state_q == DONE)   && !abort;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx      <= '0;
      vec      <= '0;
      tt       <= '0;
      ones_cnt <= '0;
      err_idx  <= '0;
      mis_seen <= 1'b0;
      match    <= 1'b0;
      valid    <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        idx      <= '0;
        vec      <= '0;
        tt       <= '0;
        ones_cnt <= '0;
        err_idx  <= '0;
        mis_seen <= 1'b0;
        match    <= 1'b0;
        valid    <= 1'b0;
      end
      if (do_sample) begin
        tt[idx]  <= s_in;
        ones_cnt <= ones_cnt + {{(CNT_W-1){1'b0}}, s_in};
        if ((s_in != GOLDEN[idx]) && !mis_seen) begin
          err_idx  <= idx;
          mis_seen <= 1'b1;
        end
        // Vector advances only on the way back into SETTLE, so it is
        // stable for the whole settle window and through SAMPLE.
        if (idx != {IDX_W{1'b1}}) begin
          idx <= idx + 1'b1;
          vec <= idx + 1'b1;
        end
      end
      if (finish) begin
        done  <= 1'b1;
        valid <= 1'b1;
        match <= (tt == GOLDEN);
      end
    end
  end

  assign {a, b, c, d} = vec;
  assign busy         = (state_q == SETTLE) || (state_q == SAMPLE);

endmodule

// File: tb/tb_ex01f_sweep_ctrl.sv
module tb_ex01f_sweep_ctrl;

  logic clk = 1'b0;
  logic rst_n, start, abort, zero_fu;
  logic a, b, c, d, s_in, busy, done, valid, match;
  logic [15:0] tt;
  logic [4:0]  ones_cnt;
  logic [3:0]  err_idx;

  logic start3;
  logic a3, b3, c3, d3, s3, busy3, done3, valid3, match3;
  logic [15:0] tt3;
  logic [4:0]  ones3;
  logic [3:0]  err3;
  logic        abort3 = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Function unit under characterisation: s = ~a&b | a&b&~c&d  (table 0x20F0)
  assign s_in = zero_fu ? 1'b0 : ((~a & b) | (a & b & ~c & d));
  assign s3   = (~a3 & b3) | (a3 & b3 & ~c3 & d3);

  ex01f_sweep_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .s_in(s_in),
    .a(a), .b(b), .c(c), .d(d), .busy(busy), .done(done), .valid(valid),
    .tt(tt), .ones_cnt(ones_cnt), .match(match), .err_idx(err_idx)
  );

  ex01f_sweep_ctrl #(.SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3), .s_in(s3),
    .a(a3), .b(b3), .c(c3), .d(d3), .busy(busy3), .done(done3), .valid(valid3),
    .tt(tt3), .ones_cnt(ones3), .match(match3), .err_idx(err3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Start accepted at the next rising edge; returns just after that edge.
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Runs a sweep; cyc = edges from acceptance to done, -1 on timeout.
  task automatic sweep(input int repulse, output int cyc);
    pulse_start();
    cyc = -1;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk);
      #1 start = 1'b0;
      if (done) begin
        cyc = i;
        break;
      end
      if (i == repulse) start = 1'b1;
    end
  endtask

  task automatic chk_results(input string tag, input logic [15:0] e_tt, input logic [4:0] e_ones,
                             input logic e_match, input logic [3:0] e_err);
    chk({tag, "_tt"},    tt,       e_tt);
    chk({tag, "_ones"},  ones_cnt, e_ones);
    chk({tag, "_match"}, match,    e_match);
    chk({tag, "_err"},   err_idx,  e_err);
    chk({tag, "_valid"}, valid,    1'b1);
  endtask

  initial begin
    int cyc;
    int seen;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; zero_fu = 1'b0; start3 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", {a, b, c, d, busy, done, valid, tt, ones_cnt, match, err_idx}, 32'h0);
    @(negedge clk) rst_n = 1'b1;

    // 1: real function unit
    sweep(0, cyc);
    chk("s1_done_cycle", cyc, 33);
    chk_results("s1", 16'h20F0, 5'd5, 1'b1, 4'd0);
    @(posedge clk); #1;
    chk("s1_done_pulse", done, 1'b0);
    chk("s1_valid_hold", valid, 1'b1);

    // 2: s tied low; first mismatch is vector 4
    zero_fu = 1'b1;
    sweep(0, cyc);
    chk("s2_done_cycle", cyc, 33);
    chk_results("s2", 16'h0000, 5'd0, 1'b0, 4'd4);
    zero_fu = 1'b0;

    // 3: abort while vector 7 is applied
    pulse_start();
    repeat (14) @(posedge clk);
    #1 chk("s3_vec7", {a, b, c, d}, 4'd7);
    @(negedge clk) abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    chk("s3_busy_after_abort", busy, 1'b0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) seen = 1;
    end
    chk("s3_no_done", seen, 0);
    chk("s3_valid", valid, 1'b0);
    sweep(0, cyc);
    chk("s3_rerun_cycle", cyc, 33);
    chk_results("s3_rerun", 16'h20F0, 5'd5, 1'b1, 4'd0);

    // 4: start re-pulsed mid-sweep is ignored
    sweep(10, cyc);
    chk("s4_done_cycle", cyc, 33);
    chk_results("s4", 16'h20F0, 5'd5, 1'b1, 4'd0);
    @(negedge clk) begin start = 1'b1; abort = 1'b1; end
    @(posedge clk);
    #1 begin start = 1'b0; abort = 1'b0; end
    chk("s4_start_abort_busy", busy, 1'b0);
    repeat (3) @(posedge clk);
    #1 chk("s4_still_idle", busy, 1'b0);
    chk("s4_valid_kept", valid, 1'b1);

    // 5: reset mid-sweep at vector 9
    pulse_start();
    repeat (18) @(posedge clk);
    #1 chk("s5_vec9", {a, b, c, d}, 4'd9);
    chk("s5_partial_ones", ones_cnt, 5'd4);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk);
    #1 chk("s5_rst_outputs", {a, b, c, d, busy, done, valid, tt, ones_cnt, match, err_idx}, 32'h0);
    rst_n = 1'b1;
    sweep(0, cyc);
    chk("s5_rerun_cycle", cyc, 33);
    chk_results("s5", 16'h20F0, 5'd5, 1'b1, 4'd0);

    // 6: SETTLE_CYCLES=3 -> vector k held over cycles 4k..4k+3, done at 65
    @(negedge clk) start3 = 1'b1;
    @(posedge clk);
    #1 start3 = 1'b0;
    cyc = -1;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk); #1;
      if (i < 64 && (i % 4) == 3) chk("s6_vec_hold", {a3, b3, c3, d3}, i / 4);
      if (done3) begin
        cyc = i;
        break;
      end
    end
    chk("s6_done_cycle", cyc, 65);
    chk("s6_tt", tt3, 16'h20F0);
    chk("s6_ones", ones3, 5'd5);
    chk("s6_match", match3, 1'b1);
    chk("s6_valid", valid3, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
